// File: rtl/div_rate_arbiter.sv
// div_rate_arbiter
//
// Shares one rate-selectable clock divider among NREQ requesters. Requesters
// are served in round-robin order. The granted requester's 2-bit rate code
// is applied to the divider's sel input only on a toggle of the divider
// output, so a period is never cut short. Each applied rate is then held for
// at least HOLD output toggles before another requester can take over.
//
// Parameters:
//   NREQ    - number of requesters (2..8)
//   HOLD    - minimum number of q_in toggles a granted rate stays applied (>=1)
//   DEF_SEL - rate code driven on sel after reset
//
// Ports:
//   clk      in   single clock domain
//   rst      in   asynchronous reset, active-high
//   req      in   NREQ level-sensitive request lines
//   req_sel  in   rate code of requester i on bits [2i+1:2i]
//   q_in     in   divider output q, fed back
//   sel      out  rate code driven to the divider
//   gnt      out  one-hot grant, zero when nothing is granted
//   busy     out  high whenever the arbiter is not idle
//   sw_done  out  one-cycle pulse on the cycle sel takes a new value
//
// Build option:
//   DIV_ARB_SYNC_EN - when defined, q_in passes through a two-flop
//                     synchronizer before toggle detection, so the divider
//                     may sit in an unrelated clock domain. This adds two
//                     cycles between a q_in toggle and the sel update.

module div_rate_arbiter #(
    parameter int         NREQ    = 4,
    parameter int         HOLD    = 8,
    parameter logic [1:0] DEF_SEL = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_sel,
    input  logic              q_in,
    output logic [1:0]        sel,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              sw_done
);

    localparam int              LW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              HW       = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [HW-1:0]   HOLD_CNT = HW'(HOLD);
    localparam logic [LW-1:0]   LAST_RST = LW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_WAIT_EDGE,
        S_HOLD
    } state_t;

    state_t          state;
    logic            q_s;
    logic            q_d;
    logic            tog;
    logic [HW-1:0]   hcnt;
    logic [LW-1:0]   last;
    logic [1:0]      pend;
    logic            found;
    logic [LW-1:0]   win;
    logic [1:0]      win_sel;
    logic            others;

`ifdef DIV_ARB_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer so q_in may come from another clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], q_in};
        end
    end

    assign q_s = sync_q[1];
`else
    assign q_s = q_in;
`endif

    // Delayed copy of the (possibly synchronized) divider output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_d <= 1'b0;
        end else begin
            q_d <= q_s;
        end
    end

    assign tog = q_s ^ q_d;

    // Round-robin search starting just after the most recent winner.
    always_comb begin
        found = 1'b0;
        win   = last;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last) + k) % NREQ]) begin
                found = 1'b1;
                win   = LW'((int'(last) + k) % NREQ);
            end
        end
    end

    assign win_sel = req_sel[{win, 1'b0} +: 2];

    // Any requester other than the current owner is waiting.
    assign others = |(req & ~(ONE << last));

    // Arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            sel     <= DEF_SEL;
            gnt     <= '0;
            busy    <= 1'b0;
            sw_done <= 1'b0;
            hcnt    <= '0;
            last    <= LAST_RST;
            pend    <= DEF_SEL;
        end else begin
            sw_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    gnt <= '0;
                    if (|req) begin
                        state <= S_ARB;
                        busy  <= 1'b1;
                    end
                end

                S_ARB: begin
                    if (!found) begin
                        gnt   <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gnt  <= ONE << win;
                        last <= win;
                        pend <= win_sel;
                        hcnt <= '0;
                        // A code already on the divider needs no edge wait.
                        if (win_sel == sel) begin
                            state <= S_HOLD;
                        end else begin
                            state <= S_WAIT_EDGE;
                        end
                    end
                end

                S_WAIT_EDGE: begin
                    // Withdrawal takes priority over a coincident toggle.
                    if (!req[last]) begin
                        gnt   <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (tog) begin
                        sel     <= pend;
                        sw_done <= 1'b1;
                        hcnt    <= '0;
                        state   <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (hcnt == HOLD_CNT) begin
                        if (!req[last]) begin
                            gnt   <= '0;
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else if (others) begin
                            gnt   <= '0;
                            state <= S_ARB;
                        end
                    end else if (tog) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end

                default: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_rate_arbiter.md
# div_rate_arbiter

Shares the team's rate-selectable clock divider among several requesters. Each requester asks for one of the divider's four 2-bit rate codes; the block grants one requester at a time using round-robin order and drives the divider's `sel` input. A new rate is applied only on a toggle of the divider output `q`, so the rate never changes mid-period. Each rate is then held for a minimum number of `q` toggles before the divider can be handed to another requester.

## Interface
- `NREQ`, default 4: number of requesters, from 2 to 8.
- `HOLD`, default 8: minimum number of `q_in` toggles a granted rate stays applied (at least 1).
- `DEF_SEL`, default 2'b00: value of `sel` after reset.

- `clk`  in  1: single clock domain.
- `rst`  in  1: asynchronous reset, active-high.
- `req`  in  NREQ: request lines, level-sensitive, one per requester.
- `req_sel`  in  2*NREQ: rate code for requester i, carried on bits [2i+1:2i].
- `q_in`  in  1: divider output `q`, fed back.
- `sel`  out  2: rate code driven to the divider.
- `gnt`  out  NREQ: one-hot grant, or all zeros when nothing is granted.
- `busy`  out  1: high whenever the state is not IDLE.
- `sw_done`  out  1: one-cycle pulse on the cycle `sel` takes a new value.

## Operation
- Toggle detect: `q_d` registers `q_in`; `tog = q_in ^ q_d`.
- The round-robin pointer `last` holds the index of the most recent winner. Search order is `last+1` upward, wrapping modulo NREQ. `last` resets to NREQ-1, so requester 0 has first priority.
- States:
  - IDLE: `gnt`=0. If any `req` bit is 1, go to ARB.
  - ARB: select the winner w from the `req` bits in this cycle. Set `gnt`=1<<w, `last`=w, and latch `pend`=req_sel[w].
    - If no `req` bit is 1 (requests withdrawn), return to IDLE.
    - If `pend`==`sel`, go directly to HOLD with `hcnt`=0 and no `sw_done` pulse.
    - Otherwise go to WAIT_EDGE.
  - WAIT_EDGE: when `tog`=1, set `sel`=`pend`, pulse `sw_done`, set `hcnt`=0, go to HOLD. If `req[w]` drops before `tog`, clear `gnt`, return to IDLE, and leave `sel` unchanged. When both happen in the same cycle, the abort wins.
  - HOLD: each `tog` increments `hcnt`, saturating at HOLD. Once `hcnt`==HOLD:
    - If `req[w]`=0, clear `gnt` and go to IDLE.
    - If any other `req` bit is 1, clear `gnt` and go to ARB.
    - Otherwise stay in HOLD, with the owner keeping the grant.
- While in HOLD, a drop of `req[w]` does not end the hold early; `gnt` stays asserted until `hcnt`==HOLD.
- While in HOLD, changes to `req_sel` are ignored. The code is sampled only in ARB.
- `hcnt` is sized to clog2(HOLD+1) bits.
- Reset values: state=IDLE, `sel`=DEF_SEL, `gnt`=0, `busy`=0, `sw_done`=0, `q_d`=0, `hcnt`=0, `last`=NREQ-1.
- An asynchronous reset in any state returns all registers to these values immediately. The divider sees `sel`=DEF_SEL.

## Timing
- All outputs are registered. State and `gnt` update on the rising edge of `clk`.
- `req` rising in IDLE (sampled at edge t): state=ARB after edge t; `gnt` and `busy`... `busy`=1 from edge t; `gnt` valid after edge t+1.
- `sel` and `sw_done` update at the first `clk` edge on which `tog`=1, i.e. one cycle after `q_in` toggles.
- A release from HOLD takes effect on the clock edge after the HOLD-th toggle is counted. The next grant, if any, is visible one cycle later.
- `sw_done` is high for exactly one cycle per applied change. It never asserts for an aborted or same-code grant.

## Configuration
- `DIV_ARB_SYNC_EN`:
  - When defined, `q_in` passes through a two-flop synchronizer (reset to 0) before toggle detection. This adds 2 cycles to the latency from a `q_in` toggle to a `sel` update, and allows `q_in` to come from an unrelated domain.
  - When undefined, `q_in` feeds `q_d` and the `tog` detect directly, for the same-clock divider.

## Test plan
- Reset behaviour: assert `rst` asynchronously mid-HOLD with `sel`=2'b10. Required: `sel`=DEF_SEL (00), `gnt`=0 and `busy`=0 immediately, without waiting for a clock edge.
- Single request: `req`=0001 with `req_sel[1:0]`=2'b11. Required: `gnt`=0001 two cycles later; `sel`=11 and one `sw_done` pulse the cycle after the next `q_in` toggle; `gnt` drops only after 8 toggles have been counted and the request is removed.
- Round-robin: hold `req`=1111 with HOLD=2. Required: grant sequence 0001, 0010, 0100, 1000, 0001, with each grant lasting at least 2 toggles.
- Abort: `req`=0010 is granted with a differing code, then `req[1]` drops before any toggle. Required: `gnt`=0, state returns to IDLE, `sel` unchanged, no `sw_done`.
- Same code: requested code equals the current `sel`. Required: direct entry to HOLD, no `sw_done`, `sel` stable throughout.
- Synchronizer build (`DIV_ARB_SYNC_EN` defined): `q_in` toggles at cycle t. Required: `sel` updates at t+3 rather than t+1.
